// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues {rw,addr,data} commands and issues them to i2c_top one at a time; define I2C_SEQ_TIMEOUT_EN for the watchdog
module i2c_cmd_sequencer #(
  parameter int CMD_DEPTH      = 4,
  parameter int RD_DEPTH       = 4,
  parameter int ENABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       err,
  input  logic       err_clr,
  output logic [6:0] m_addr,
  output logic [7:0] m_data_in,
  output logic       m_rw,
  output logic       m_enable,
  input  logic       m_ready,
  input  logic [7:0] m_data_out
);
  localparam int CW = $clog2(CMD_DEPTH);
  localparam int RW = $clog2(RD_DEPTH);
  localparam int EW = $clog2(ENABLE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t        state;
  logic [15:0]   cmd_mem [CMD_DEPTH];
  logic [7:0]    rd_mem [RD_DEPTH];
  logic [CW:0]   cmd_wp, cmd_rp;
  logic [RW:0]   rd_wp, rd_rp;
  logic [EW-1:0] en_cnt;
  logic [15:0]   head;
  logic          cmd_empty, cmd_full, rd_empty, rd_full;
  logic          cmd_push, rd_pop, rd_push, start, timeout;
  assign cmd_empty = cmd_wp == cmd_rp;
  assign cmd_full  = cmd_wp == {~cmd_rp[CW], cmd_rp[CW-1:0]};
  assign rd_empty  = rd_wp == rd_rp;
  assign rd_full   = rd_wp == {~rd_rp[RW], rd_rp[RW-1:0]};
  assign cmd_ready = !cmd_full;
  assign rd_valid  = !rd_empty;
  assign cmd_push  = cmd_valid && !cmd_full;
  assign rd_pop    = rd_valid && rd_ready;
  assign head      = cmd_mem[cmd_rp[CW-1:0]];
  assign rd_data   = rd_empty ? 8'h00 : rd_mem[rd_rp[RW-1:0]];
  assign busy      = state != IDLE || !cmd_empty;
  // a read is only started while the read FIFO has room, so its result always fits
  assign start     = state == IDLE && !cmd_empty && m_ready && !(head[15] && rd_full);
  assign rd_push   = state == WAIT_DONE && m_ready && m_rw;
  // FIFO pointers with wrap bit; push and pop may happen in the same cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cmd_wp <= '0;
      cmd_rp <= '0;
      rd_wp  <= '0;
      rd_rp  <= '0;
    end else begin
      cmd_wp <= cmd_wp + (CW+1)'(cmd_push);
      cmd_rp <= cmd_rp + (CW+1)'(start);
      rd_wp  <= rd_wp + (RW+1)'(rd_push);
      rd_rp  <= rd_rp + (RW+1)'(rd_pop);
    end
  // FIFO storage; contents are qualified by the pointers so no reset is needed
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wp[CW-1:0]] <= {cmd_rw, cmd_addr, cmd_data};
    if (rd_push) rd_mem[rd_wp[RW-1:0]] <= m_data_out;
  end
  // transaction sequencer: latch head, pulse enable, then follow the master's ready handshake
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      en_cnt    <= '0;
      m_enable  <= 1'b0;
      m_addr    <= '0;
      m_data_in <= '0;
      m_rw      <= 1'b0;
    end else if (timeout) state <= IDLE;
    else
      case (state)
        IDLE: if (start) begin
          {m_rw, m_addr, m_data_in} <= head;
          m_enable <= 1'b1;
          en_cnt   <= '0;
          state    <= ISSUE;
        end
        ISSUE: begin
          en_cnt <= en_cnt + 1'b1;
          if (en_cnt == EW'(ENABLE_CYCLES - 1)) begin
            m_enable <= 1'b0;
            state    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: if (!m_ready) state <= WAIT_DONE;
        WAIT_DONE: if (m_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] t_cnt;
  logic          waiting;
  assign waiting = state == WAIT_BUSY || state == WAIT_DONE;
  // a completion arriving on the last allowed cycle still wins over the watchdog
  assign timeout = waiting && !(state == WAIT_DONE && m_ready) && t_cnt == TW'(TIMEOUT_CYCLES - 1);
  // watchdog counts wait-state cycles per transaction; err is sticky until err_clr
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      t_cnt <= '0;
      err   <= 1'b0;
    end else begin
      t_cnt <= state == ISSUE ? '0 : waiting ? t_cnt + 1'b1 : t_cnt;
      err   <= err_clr ? 1'b0 : (err | timeout);
    end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign timeout = 1'b0;
  assign err = 1'b0;
`endif
endmodule
